// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Port response FSM states plus data/strobe widths.
package sram_arb_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    HOLD
  } port_state_e;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req (N), ptr (IW) in; gnt one-hot (N), idx (IW), any out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   s;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      // wrap ptr+i modulo N (N need not be a power of two)
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N_PORTS.
// Ports: req_* request channels, rsp_* response channels, sram_* pins.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_valid,
  output logic [N_PORTS-1:0]          req_ready,
  input  logic [N_PORTS-1:0]          req_we,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*STRB_W-1:0]   req_wstrb,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          rsp_valid,
  input  logic [N_PORTS-1:0]          rsp_ready,
  output logic [N_PORTS*DATA_W-1:0]   rsp_rdata,
  output logic                        sram_cs,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_a,
  output logic [STRB_W-1:0]           sram_byte,
  output logic [DATA_W-1:0]           sram_di,
  input  logic [DATA_W-1:0]           sram_do
);

  localparam int IW = $clog2(N_PORTS);

  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               gany;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]  a_q;
  logic [DATA_W-1:0]  di_q;
  logic [ADDR_W-1:0]  g_addr;
  logic [STRB_W-1:0]  g_strb;
  logic [DATA_W-1:0]  g_data;
  logic               g_we;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    port_state_e       st_q, st_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] fl_data;

    assign fl_data = wr_q ? '0 : sram_do;
    assign rsp_valid[p] = (st_q != IDLE);
    assign rsp_rdata[p*DATA_W +: DATA_W] =
      (st_q == FLIGHT) ? fl_data :
      (st_q == HOLD)   ? hold_q  : '0;
    // a port may be re-granted in the cycle its response drains
    assign elig[p] = req_valid[p] & ~rst &
      ((st_q == IDLE) | (rsp_valid[p] & rsp_ready[p]));

    always_comb begin
      st_d   = st_q;
      wr_d   = wr_q;
      hold_d = hold_q;
      if (gnt[p]) begin
        st_d = FLIGHT;
        wr_d = req_we[p];
      end else begin
        unique case (st_q)
          FLIGHT: begin
            if (rsp_ready[p]) begin
              st_d = IDLE;
            end else begin
              st_d   = HOLD;
              hold_d = fl_data;
            end
          end
          HOLD: if (rsp_ready[p]) st_d = IDLE;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= IDLE;
        wr_q   <= 1'b0;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        wr_q   <= wr_d;
        hold_q <= hold_d;
      end
    end
  end

  rr_arbiter #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready = gnt;

  always_comb begin
    g_addr = '0;
    g_strb = '0;
    g_data = '0;
    g_we   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) begin
        g_addr = req_addr[p*ADDR_W +: ADDR_W];
        g_strb = req_wstrb[p*STRB_W +: STRB_W];
        g_data = req_wdata[p*DATA_W +: DATA_W];
        g_we   = req_we[p];
      end
    end
  end

  // byte enables double as write enables in the macro: zero on reads
  assign sram_cs   = gany;
  assign sram_we   = gany & g_we;
  assign sram_byte = (gany & g_we) ? g_strb : '0;
  assign sram_a    = gany ? g_addr : a_q;
  assign sram_di   = gany ? g_data : di_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gany) begin
      ptr_d = (gidx == IW'(N_PORTS-1)) ? '0 : gidx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      a_q   <= '0;
      di_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      a_q   <= sram_a;
      di_q  <= sram_di;
    end
  end

endmodule
